vga_led_decoder: RTL and testbench
==================================

// Module: vga_led_decoder
// PURPOSE
//  Receive end of the VGA link: consumes hsync/vsync/green from the VGA generator and recovers the 8-bit LED vector drawn as 8 circles.
//  Locks to 640x480@800x525 timing, samples one pixel per circle centre on row 240, republishes the vector once per frame.
//  Self-check/loopback block in the vga_clk domain, for board bring-up and regression of the game display path.
// PARAMETERS
//  H_TOTAL      800  expected clocks per line (hsync fall to hsync fall)
//  H_SYNC       96   expected hsync low width, clocks
//  V_TOTAL      525  expected lines per frame (vsync fall to vsync fall)
//  X0           265  h_cnt of LED7 sample (144 active start + 120 centre + 1 generator output reg)
//  DX           60   h_cnt step between LEDs; LED(7-i) sampled at X0+i*DX
//  SAMPLE_Y     275  v_cnt of sample row (35 + 240)
//  G_THRESH     8    green >= G_THRESH decodes as 1
//  LOCK_FRAMES  2    consecutive good frames required for lock
// PORTS
//  clk        in   1  pixel clock, same as generator clock
//  rst        in   1  reset, asynchronous, active-low
//  hsync      in   1  active-low horizontal sync
//  vsync      in   1  active-low vertical sync
//  vga_g      in   4  green channel
//  led_dec    out  8  decoded LED vector, bit7 = leftmost circle
//  frame_vld  out  1  1-cycle pulse when led_dec updated
//  locked     out  1  timing locked
//  sync_err   out  1  1-cycle pulse on any timing violation
// BEHAVIOUR
//  - Reset (rst=0, async): led_dec=0, frame_vld=0, locked=0, sync_err=0, counters 0, FSM=SEARCH. All outputs registered.
//  - hsync/vsync/vga_g registered once (in_q) before all logic; edges = in_q vs 1-cycle-delayed copy.
//  - h_cnt(10b): 0 in cycle of hsync_q fall, else +1; saturates at 1023. hs_w counts low width; latched at rise.
//  - v_cnt(10b): 0 on the line whose hsync fall coincides with/follows vsync_q fall, else +1 per hsync fall; saturates 1023.
//  - Line check at each hsync fall: prior h_cnt+1 == H_TOTAL and hs_w == H_SYNC. Frame check at vsync fall: line count == V_TOTAL.
//  - h_cnt or v_cnt reaching saturation = violation (lost sync), no edge needed.
//  - FSM: SEARCH --first vsync fall--> MEASURE (good=0).
//    MEASURE: good frame end -> good+1; good+1 == LOCK_FRAMES -> LOCKED, locked=1.
//    Any violation in MEASURE/LOCKED -> SEARCH, locked=0, sync_err=1 one cycle, sample reg cleared.
//    Violation in SEARCH: no pulse.
//  - Sampling: when v_cnt==SAMPLE_Y and h_cnt==X0+i*DX (i=0..7), samp[7-i] <= (g_q >= G_THRESH).
//  - Frame end (vsync fall) while LOCKED and frame check passes: led_dec<=samp, frame_vld=1 same cycle as locked update. First update = frame after lock.
//  - Latency: pixel to led_dec at next vsync fall + 1 clk (input reg); frame_vld coincident with new led_dec.
//  - Simultaneous violation + frame end: violation wins, led_dec holds, frame_vld=0.
//  - Mid-frame reset: immediate clear; relock needs SEARCH + LOCK_FRAMES full frames.
//  - led_dec holds last value while unlocked.
// CONFIGURATION
//  VGA_DEC_MAJORITY_EN defined: each LED samples h_cnt-1, h_cnt, h_cnt+1 on SAMPLE_Y; bit = majority (>=2 of 3) of threshold results.
//    Latency unchanged (vote resolved at frame end).
//  Undefined: single sample at h_cnt exactly.
// TESTING
//  1 Reset: hold rst=0 mid-line -> all outputs 0; release, 3 ideal frames of led=8'hA5 -> locked=1 at end of frame 2, led_dec=A5 + frame_vld at end of frame 3.
//  2 Shift: generator led 01,02,04..80 one per frame -> led_dec tracks each, one frame lag, exactly one frame_vld per frame.
//  3 Bad line: one line 801 clocks while locked -> sync_err 1 cycle, locked=0, led_dec held; relock after 2 good frames.
//  4 Sync width: hsync low 95 clocks on one line -> sync_err, SEARCH.
//  5 Lost sync: vsync stuck high >1023 lines -> sync_err once at saturation, locked=0, no frame_vld.
//  6 Glitch: green=F only at h_cnt X0+1, row 275 -> default build LED7=0; VGA_DEC_MAJORITY_EN build LED7=0; green F at X0-1..X0 -> both builds LED7=1.

Source files
------------

// File: rtl/vga_led_decoder.sv
// vga_led_decoder: receive end of the VGA LED link.
// Locks to the incoming hsync/vsync timing, samples one green pixel per LED
// circle centre on the sample row and republishes the 8-bit vector once per
// frame while locked.
// Build option: define VGA_DEC_MAJORITY_EN to decide each LED by a 2-of-3 vote
// over h_cnt-1, h_cnt, h_cnt+1 instead of a single sample at the centre.
//
//  state   | meaning
//  SEARCH  | waiting for the first vsync fall, violations ignored
//  MEASURE | counting consecutive good frames towards lock
//  LOCKED  | timing trusted, led_dec republished at each good frame end
module vga_led_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int V_TOTAL     = 525,
  parameter int X0          = 265,
  parameter int DX          = 60,
  parameter int SAMPLE_Y    = 275,
  parameter int G_THRESH    = 8,
  parameter int LOCK_FRAMES = 2,
  parameter int CNT_W       = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [3:0] vga_g,
  output logic [7:0] led_dec,
  output logic       frame_vld,
  output logic       locked,
  output logic       sync_err
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_PRE    = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W:0]   POS_ONE    = (CNT_W+1)'(1);
  localparam logic [CNT_W:0]   H_TOT_L    = (CNT_W+1)'(H_TOTAL);
  localparam logic [CNT_W:0]   V_TOT_L    = (CNT_W+1)'(V_TOTAL);
  localparam logic [CNT_W-1:0] H_SYNC_L   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] SAMPLE_Y_L = CNT_W'(SAMPLE_Y);
  localparam logic [3:0]       G_THRESH_L = 4'(G_THRESH);
  localparam logic [3:0]       LOCK_L     = 4'(LOCK_FRAMES);

  logic             hs_q, vs_q, hs_d, vs_d;
  logic [3:0]       g_q;
  logic             hs_fall, hs_rise, vs_fall;
  logic [CNT_W-1:0] h_cnt, v_cnt, hs_low, hs_w;
  logic             vs_pend, v_clr;
  logic [CNT_W:0]   h_nxt, h_pos;
  logic             h_sat, v_sat, line_bad, frame_bad, viol;
  logic             g_hit, on_row;
  logic [7:0]       samp;

  state_t     state, state_n;
  logic [3:0] good, good_n;
  logic [7:0] led_n;
  logic       vld_n, lock_n, err_n, clr;

  // Input register plus one delayed copy of the syncs for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      hs_d <= 1'b1;
      vs_d <= 1'b1;
      g_q  <= '0;
    end else begin
      hs_q <= hsync;
      vs_q <= vsync;
      hs_d <= hs_q;
      vs_d <= vs_q;
      g_q  <= vga_g;
    end
  end

  assign hs_fall = hs_d & ~hs_q;
  assign hs_rise = ~hs_d & hs_q;
  assign vs_fall = vs_d & ~vs_q;

  // A vsync fall restarts v_cnt on the line whose hsync fall coincides with or follows it.
  assign v_clr = vs_fall | vs_pend;

  // h_pos is the horizontal position of the pixel currently in g_q: 0 in the
  // hsync fall cycle, otherwise one past the registered count.
  assign h_nxt = {1'b0, h_cnt} + POS_ONE;
  assign h_pos = hs_fall ? '0 : h_nxt;

  assign h_sat     = ~hs_fall & (h_cnt == CNT_PRE);
  assign v_sat     = hs_fall & ~v_clr & (v_cnt == CNT_PRE);
  assign line_bad  = hs_fall & ((h_nxt != H_TOT_L) | (hs_w != H_SYNC_L));
  assign frame_bad = vs_fall & (({1'b0, v_cnt} + POS_ONE) != V_TOT_L);
  assign viol      = line_bad | frame_bad | h_sat | v_sat;

  // Line/frame counters and hsync low-width measurement, all saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      hs_low  <= '0;
      hs_w    <= '0;
      vs_pend <= 1'b0;
    end else begin
      if (hs_fall)
        h_cnt <= '0;
      else if (h_cnt != CNT_MAX)
        h_cnt <= h_cnt + CNT_ONE;

      if (hs_fall)
        hs_low <= CNT_ONE;
      else if (!hs_q && hs_low != CNT_MAX)
        hs_low <= hs_low + CNT_ONE;

      if (hs_rise)
        hs_w <= hs_low;

      if (hs_fall) begin
        if (v_clr)
          v_cnt <= '0;
        else if (v_cnt != CNT_MAX)
          v_cnt <= v_cnt + CNT_ONE;
      end

      if (hs_fall)
        vs_pend <= 1'b0;
      else if (vs_fall)
        vs_pend <= 1'b1;
    end
  end

  assign g_hit  = (g_q >= G_THRESH_L);
  assign on_row = (v_cnt == SAMPLE_Y_L);

`ifdef VGA_DEC_MAJORITY_EN
  logic [7:0] s_m, s_c, s_p;

  // Three taps per LED around the centre; the vote is taken when published.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_m <= '0;
      s_c <= '0;
      s_p <= '0;
    end else if (clr) begin
      s_m <= '0;
      s_c <= '0;
      s_p <= '0;
    end else if (on_row) begin
      for (int i = 0; i < 8; i++) begin
        if (h_pos == (CNT_W+1)'(X0 + i*DX - 1)) s_m[7-i] <= g_hit;
        if (h_pos == (CNT_W+1)'(X0 + i*DX))     s_c[7-i] <= g_hit;
        if (h_pos == (CNT_W+1)'(X0 + i*DX + 1)) s_p[7-i] <= g_hit;
      end
    end
  end

  assign samp = (s_m & s_c) | (s_m & s_p) | (s_c & s_p);
`else
  logic [7:0] s_c;

  // One sample per LED exactly at the circle centre.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_c <= '0;
    end else if (clr) begin
      s_c <= '0;
    end else if (on_row) begin
      for (int i = 0; i < 8; i++) begin
        if (h_pos == (CNT_W+1)'(X0 + i*DX)) s_c[7-i] <= g_hit;
      end
    end
  end

  assign samp = s_c;
`endif

  // Lock FSM next-state and next-output; a violation outranks a frame end.
  always_comb begin
    state_n = state;
    good_n  = good;
    led_n   = led_dec;
    vld_n   = 1'b0;
    lock_n  = locked;
    err_n   = 1'b0;
    clr     = 1'b0;
    case (state)
      SEARCH: begin
        if (vs_fall) begin
          state_n = MEASURE;
          good_n  = '0;
        end
      end
      MEASURE: begin
        if (viol) begin
          state_n = SEARCH;
          lock_n  = 1'b0;
          err_n   = 1'b1;
          clr     = 1'b1;
        end else if (vs_fall) begin
          good_n = good + 4'd1;
          if (good + 4'd1 == LOCK_L) begin
            state_n = LOCKED;
            lock_n  = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (viol) begin
          state_n = SEARCH;
          lock_n  = 1'b0;
          err_n   = 1'b1;
          clr     = 1'b1;
        end else if (vs_fall) begin
          led_n = samp;
          vld_n = 1'b1;
        end
      end
      default: begin
        state_n = SEARCH;
        lock_n  = 1'b0;
      end
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SEARCH;
      good      <= '0;
      led_dec   <= '0;
      frame_vld <= 1'b0;
      locked    <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      state     <= state_n;
      good      <= good_n;
      led_dec   <= led_n;
      frame_vld <= vld_n;
      locked    <= lock_n;
      sync_err  <= err_n;
    end
  end

endmodule

// File: tb/tb_vga_led_decoder.sv
// tb_vga_led_decoder: scoreboard bench for the VGA LED decoder, using a
// shrunken raster so whole frames and sync loss fit in a short run.
module tb_vga_led_decoder;

  localparam int HT = 48;
  localparam int HS = 6;
  localparam int VT = 32;
  localparam int X0 = 16;
  localparam int DX = 4;
  localparam int SY = 20;
  localparam int GT = 8;
  localparam int LF = 2;
  localparam int CW = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       hsync, vsync;
  logic [3:0] vga_g;
  logic [7:0] led_dec;
  logic       frame_vld, locked, sync_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  int         err_q[$];

  bit         m_acq;
  int         m_good;
  logic [7:0] m_hold;
  logic [7:0] prev_led;

  always #5 clk = ~clk;

  vga_led_decoder #(
    .H_TOTAL(HT), .H_SYNC(HS), .V_TOTAL(VT), .X0(X0), .DX(DX),
    .SAMPLE_Y(SY), .G_THRESH(GT), .LOCK_FRAMES(LF), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .vga_g(vga_g),
    .led_dec(led_dec), .frame_vld(frame_vld), .locked(locked), .sync_err(sync_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame-level rules for acquisition, lock and publishing.
  task automatic model_reset();
    m_acq  = 0;
    m_good = 0;
    m_hold = 8'h00;
  endtask

  task automatic model_violation(input int tag);
    if (m_acq) err_q.push_back(tag);
    m_acq  = 0;
    m_good = 0;
  endtask

  task automatic model_frame_end();
    if (!m_acq) begin
      m_acq  = 1;
      m_good = 0;
    end else if (m_good >= LF) begin
      exp_q.push_back(prev_led);
      m_hold = prev_led;
    end else begin
      m_good++;
    end
  endtask

  // Green value for pixel p of the sample row; circles are 3 pixels wide.
  function automatic logic [3:0] pix(input int p, input logic [7:0] led, input int glitch);
    for (int i = 0; i < 8; i++) begin
      int c;
      c = X0 + i*DX;
      if (p >= c-1 && p <= c+1) begin
        if (i == 0 && glitch == 1) return (p == c+1) ? 4'hF : 4'h0;
        if (i == 0 && glitch == 2) return (p <= c) ? 4'hF : 4'h0;
        return led[7-i] ? 4'($urandom_range(15, GT)) : 4'($urandom_range(GT-1, 0));
      end
    end
    return 4'($urandom_range(15, 0));
  endfunction

  task automatic drive_line(input bit vs_lo, input int hw, input int len, input bit row,
                            input logic [7:0] led, input int glitch);
    for (int p = 0; p < len; p++) begin
      @(negedge clk);
      hsync = (p < hw) ? 1'b0 : 1'b1;
      vsync = ~vs_lo;
      vga_g = row ? pix(p, led, glitch) : 4'($urandom_range(15, 0));
    end
  endtask

  // fault: 0 none, 1 one line HT+1 long, 2 one hsync pulse HS-1 wide, 3 reset mid-frame.
  task automatic send_frame(input logic [7:0] led, input int fault, input int glitch);
    logic [7:0] dec;
    dec = led;
    if (glitch == 1) dec[7] = 1'b0;
    if (glitch == 2) dec[7] = 1'b1;
    model_frame_end();
    for (int ln = 0; ln < VT; ln++) begin
      int len, hw;
      len = HT;
      hw  = HS;
      if (ln == 2) begin
        chk("locked", {31'b0, locked}, {31'b0, (m_acq && m_good >= LF)});
        chk("led_hold", {24'b0, led_dec}, {24'b0, m_hold});
        chk("vld_pending", exp_q.size(), 0);
        chk("err_pending", err_q.size(), 0);
      end
      if (ln == 10 && fault == 1) begin
        len = HT + 1;
        model_violation(1);
      end
      if (ln == 10 && fault == 2) begin
        hw = HS - 1;
        model_violation(2);
      end
      if (ln == 15 && fault == 3) begin
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_led", {24'b0, led_dec}, 0);
        chk("midrst_lock", {31'b0, locked}, 0);
        chk("midrst_vld", {31'b0, frame_vld}, 0);
        chk("midrst_err", {31'b0, sync_err}, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
      end
      drive_line(ln < 2, hw, len, ln == SY, led, glitch);
    end
    prev_led = dec;
  endtask

  task automatic stuck_vsync();
    model_violation(5);
    for (int ln = 0; ln < 300; ln++) drive_line(1'b0, HS, HT, 1'b0, 8'h00, 0);
    chk("stuck_locked", {31'b0, locked}, 0);
    chk("stuck_err", err_q.size(), 0);
  endtask

  // Monitor: every frame_vld / sync_err cycle consumes one expected entry.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (frame_vld) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL frame_vld: unexpected pulse led_dec=%0h at %0t", led_dec, $time);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (led_dec !== e) begin
            n_fail++;
            $display("FAIL led_dec: got %0h expected %0h at %0t", led_dec, e, $time);
          end
        end
      end
      if (sync_err) begin
        n_chk++;
        if (err_q.size() == 0) begin
          n_fail++;
          $display("FAIL sync_err: unexpected pulse at %0t", $time);
        end else begin
          void'(err_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst   = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;
    vga_g = 4'h0;
    prev_led = 8'h00;
    model_reset();

    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      hsync = 1'($urandom_range(1, 0));
      vsync = 1'($urandom_range(1, 0));
      vga_g = 4'($urandom_range(15, 0));
    end
    #1;
    chk("rst_led", {24'b0, led_dec}, 0);
    chk("rst_vld", {31'b0, frame_vld}, 0);
    chk("rst_lock", {31'b0, locked}, 0);
    chk("rst_err", {31'b0, sync_err}, 0);
    @(negedge clk);
    hsync = 1'b1;
    vsync = 1'b1;
    rst   = 1'b1;
    repeat (5) @(negedge clk);

    repeat (3) send_frame(8'hA5, 0, 0);
    for (int b = 0; b < 8; b++) send_frame(8'(1 << b), 0, 0);
    send_frame(8'($urandom), 0, 0);

    send_frame(8'($urandom), 1, 0);
    repeat (4) send_frame(8'($urandom), 0, 0);

    send_frame(8'($urandom), 2, 0);
    repeat (3) send_frame(8'($urandom), 0, 0);

    stuck_vsync();
    repeat (3) send_frame(8'($urandom), 0, 0);
    send_frame(8'h3C, 0, 1);
    send_frame(8'h5A, 0, 2);
    send_frame(8'($urandom), 0, 0);

    send_frame(8'($urandom), 3, 0);
    repeat (4) send_frame(8'($urandom), 0, 0);

    repeat (3) send_frame(8'($urandom), 0, 0);

    repeat (10) @(negedge clk);
    chk("end_vld_queue", exp_q.size(), 0);
    chk("end_err_queue", err_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
